// File: rtl/timer_pwm.sv
// timer_pwm: memory-mapped 16-bit prescaled up-counter with overflow interrupt and PWM compare output
module timer_pwm #(
  parameter logic [15:0] RST_MAX = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_memAddr,
  input  logic [15:0] i_memDataIn,
  input  logic        i_memWrEn,
  output logic [15:0] o_memDataOut,
  output logic        o_intTMR,
  output logic        o_pwm
);
  logic        en_q, en_d;
  logic [7:0]  psc_q, psc_d, pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d, max_q, max_d, cmp_q, cmp_d;
  logic        int_q, int_d, pwm_q, pwm_d;
  logic        wr_ctl, wr_cnt, wr_max, wr_cmp, tick, at_max;
  always_comb begin
    wr_ctl = i_memWrEn && (i_memAddr == 2'b00);
    wr_cnt = i_memWrEn && (i_memAddr == 2'b01);
    wr_max = i_memWrEn && (i_memAddr == 2'b10);
    wr_cmp = i_memWrEn && (i_memAddr == 2'b11);
    tick   = en_q && (pc_q == psc_q);
    at_max = cnt_q >= max_q;
    en_d   = wr_ctl ? i_memDataIn[15] : en_q;
    psc_d  = wr_ctl ? i_memDataIn[7:0] : psc_q;
    pc_d   = (wr_ctl || tick || !en_q) ? 8'd0 : pc_q + 8'd1;
    // a CNT write wins over a coincident tick and suppresses its wrap
    cnt_d  = wr_cnt ? i_memDataIn : !tick ? cnt_q : at_max ? 16'd0 : cnt_q + 16'd1;
    max_d  = wr_max ? i_memDataIn : max_q;
    cmp_d  = wr_cmp ? i_memDataIn : cmp_q;
    int_d  = tick && at_max && !wr_cnt;
    pwm_d  = cnt_q < cmp_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q  <= 1'b0;
      psc_q <= 8'd0;
      pc_q  <= 8'd0;
      cnt_q <= 16'd0;
      max_q <= RST_MAX;
      cmp_q <= 16'd0;
      int_q <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      psc_q <= psc_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      cmp_q <= cmp_d;
      int_q <= int_d;
      pwm_q <= pwm_d;
    end
  end
  always_comb begin
    o_memDataOut = (i_memAddr == 2'b00) ? {en_q, 7'd0, psc_q} :
                   (i_memAddr == 2'b01) ? cnt_q :
                   (i_memAddr == 2'b10) ? max_q : cmp_q;
  end
  assign o_intTMR = int_q;
  assign o_pwm    = pwm_q;
endmodule

// File: tb/tb_timer_pwm.sv
// tb_timer_pwm: directed checks of timer_pwm against hand-computed register, interrupt and PWM values
module tb_timer_pwm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [15:0] din = 16'd0;
  logic        wen = 1'b0;
  logic [15:0] dout;
  logic        irq, pwm;
  int n_tests = 0;
  int n_fail = 0;
  timer_pwm dut (
    .i_clk(clk), .i_rst(rst), .i_memAddr(addr), .i_memDataIn(din),
    .i_memWrEn(wen), .o_memDataOut(dout), .o_intTMR(irq), .o_pwm(pwm)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a;
    din = d;
    wen = 1'b1;
    cyc(1);
    wen = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = dout;
  endtask
  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask
  initial begin
    logic [15:0] v;
    int hi, seen;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_reg("rst_ctl", 2'b00, 16'h0000);
    chk_reg("rst_cnt", 2'b01, 16'h0000);
    chk_reg("rst_max", 2'b10, 16'hFFFF);
    chk_reg("rst_cmp", 2'b11, 16'h0000);
    check("rst_int", {15'd0, irq}, 16'd0);
    check("rst_pwm", {15'd0, pwm}, 16'd0);
    // prescale/wrap: MAX=3, PSC=1
    wr(2'b10, 16'd3);
    wr(2'b00, 16'h8001);
    chk_reg("psc_ctl", 2'b00, 16'h8001);
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      chk_reg($sformatf("psc_cnt%0d", k), 2'b01, 16'((k / 2) % 4));
      check($sformatf("psc_int%0d", k), {15'd0, irq}, {15'd0, (k % 8) == 0});
    end
    wr(2'b00, 16'h0000);
    // pwm duty: MAX=9 CMP=3 PSC=0
    wr(2'b01, 16'd0);
    wr(2'b10, 16'd9);
    wr(2'b11, 16'd3);
    wr(2'b00, 16'h8000);
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (pwm) hi++;
      check($sformatf("pwm%0d", k), {15'd0, pwm}, {15'd0, ((k - 1) % 10) < 3});
    end
    check("pwm_duty", 16'(hi), 16'd6);
    wr(2'b11, 16'd0);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (pwm) hi++;
    end
    check("pwm_cmp0", 16'(hi), 16'd0);
    wr(2'b11, 16'h000A);
    cyc(1);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (pwm) hi++;
    end
    check("pwm_cmpA", 16'(hi), 16'd12);
    // write collisions with PSC=0 ticking every cycle
    wr(2'b01, 16'h0005);
    chk_reg("coll_cnt5", 2'b01, 16'd5);
    check("coll_int0", {15'd0, irq}, 16'd0);
    cyc(1);
    chk_reg("coll_cnt6", 2'b01, 16'd6);
    wr(2'b01, 16'd9);
    chk_reg("colmax_cnt", 2'b01, 16'd9);
    check("colmax_int0", {15'd0, irq}, 16'd0);
    cyc(1);
    chk_reg("colmax_wrap", 2'b01, 16'd0);
    check("colmax_int1", {15'd0, irq}, 16'd1);
    cyc(1);
    chk_reg("colmax_cnt1", 2'b01, 16'd1);
    check("colmax_int_off", {15'd0, irq}, 16'd0);
    // MAX shrink below running count
    wr(2'b10, 16'd100);
    wr(2'b01, 16'd50);
    wr(2'b10, 16'd10);
    chk_reg("shr_cnt51", 2'b01, 16'd51);
    check("shr_int0", {15'd0, irq}, 16'd0);
    cyc(1);
    chk_reg("shr_wrap", 2'b01, 16'd0);
    check("shr_int1", {15'd0, irq}, 16'd1);
    cyc(10);
    chk_reg("shr_cnt10", 2'b01, 16'd10);
    check("shr_int_mid", {15'd0, irq}, 16'd0);
    cyc(1);
    chk_reg("shr_wrap2", 2'b01, 16'd0);
    check("shr_int2", {15'd0, irq}, 16'd1);
    // disable at 7, hold, re-enable with PSC=4
    wr(2'b01, 16'd6);
    wr(2'b00, 16'h0000);
    chk_reg("dis_cnt7", 2'b01, 16'd7);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (irq) seen++;
    end
    chk_reg("dis_hold", 2'b01, 16'd7);
    check("dis_noint", 16'(seen), 16'd0);
    wr(2'b00, 16'h8004);
    chk_reg("en_ctl", 2'b00, 16'h8004);
    cyc(4);
    chk_reg("en_cnt_wait", 2'b01, 16'd7);
    cyc(1);
    chk_reg("en_cnt8", 2'b01, 16'd8);
    // ignored CTL bits, disabled write strobe
    wr(2'b00, 16'h7F12);
    chk_reg("ctl_mask", 2'b00, 16'h0012);
    addr = 2'b10;
    din = 16'h1234;
    cyc(1);
    chk_reg("nowr_max", 2'b10, 16'd10);
    // reset mid-count
    wr(2'b11, 16'h0020);
    wr(2'b00, 16'h8000);
    cyc(3);
    rst = 1'b1;
    addr = 2'b01;
    din = 16'h00AA;
    wen = 1'b1;
    cyc(2);
    rst = 1'b0;
    wen = 1'b0;
    chk_reg("rst2_ctl", 2'b00, 16'h0000);
    chk_reg("rst2_cnt", 2'b01, 16'h0000);
    chk_reg("rst2_max", 2'b10, 16'hFFFF);
    chk_reg("rst2_cmp", 2'b11, 16'h0000);
    check("rst2_int", {15'd0, irq}, 16'd0);
    check("rst2_pwm", {15'd0, pwm}, 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
